cordic_phase_gen: RTL and testbench

Phase-accumulator (NCO) front end that sits directly upstream of the 16-stage CORDIC rotation pipeline. Each enabled cycle it advances a full-circle phase. It folds the phase into the CORDIC convergence range by a quadrant pre-rotation and drives the pipeline's x_in/y_in/angle_in. It also carries a valid sideband that is delayed by the CORDIC latency, so downstream logic knows when x_out/y_out are meaningful.

---
 rtl/cordic_phase_gen.sv | 124 ++++++++++++
 tb/tb_cordic_phase_gen.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_phase_gen.sv
// Phase-accumulator front end for the CORDIC rotation pipeline: folds the phase into
// the convergence range by quadrant pre-rotation and tracks sample validity through the CORDIC latency.
module cordic_phase_gen #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned PHASE_W    = 32,
  parameter int unsigned CORDIC_LAT = 17,
  parameter int unsigned HALF_PI    = 25736
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               phase_clr,
  input  logic [PHASE_W-1:0] fcw_in,
  input  logic               fcw_load,
  input  logic [PHASE_W-1:0] phase_off,
  input  logic [WIDTH-1:0]   amp_in,
  output logic [WIDTH-1:0]   x_in,
  output logic [WIDTH-1:0]   y_in,
  output logic [WIDTH-1:0]   angle_in,
  output logic               out_valid,
  output logic               cordic_valid
);

  localparam int unsigned RES_W  = PHASE_W - 2;
  localparam int unsigned PROD_W = RES_W + WIDTH;

  localparam logic [PHASE_W-1:0]       EIGHTH    = PHASE_W'(1) << (PHASE_W - 3);
  localparam logic signed [PROD_W-1:0] HALF_PI_P = PROD_W'(HALF_PI);
  localparam logic signed [WIDTH-1:0]  AMP_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0]  AMP_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

  logic [PHASE_W-1:0]      fcw;
  logic [PHASE_W-1:0]      acc;
  logic                    v1;
  logic [1:0]              q1;
  logic signed [RES_W-1:0] res1;
  logic signed [WIDTH-1:0] amp1;
  logic [CORDIC_LAT-1:0]   dly;

  logic [PHASE_W-1:0]      rot_c;
  logic signed [RES_W-1:0] res_c;
  logic signed [WIDTH-1:0] neg_c;
  logic signed [WIDTH-1:0] x_c;
  logic signed [WIDTH-1:0] y_c;
  logic signed [WIDTH-1:0] angle_c;

  // Offsetting by an eighth turn centres each quadrant's residual on zero.
  always_comb begin
    rot_c = acc + phase_off + EIGHTH;
    res_c = {~rot_c[PHASE_W-3], rot_c[PHASE_W-4:0]};
  end

  // Residual scaled to CORDIC angle units; the arithmetic shift floors toward -inf.
  always_comb begin
    angle_c = WIDTH'((PROD_W'(res1) * HALF_PI_P) >>> RES_W);
  end

  // Quadrant pre-rotation with saturating negation of the most negative amplitude.
  always_comb begin
    neg_c = (amp1 == AMP_MIN) ? AMP_MAX : -amp1;
    x_c   = '0;
    y_c   = '0;
    case (q1)
      2'd0:    x_c = amp1;
      2'd1:    y_c = amp1;
      2'd2:    x_c = neg_c;
      default: y_c = neg_c;
    endcase
  end

  // Frequency word and phase accumulator; clear wins over enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fcw <= '0;
      acc <= '0;
    end else begin
      if (fcw_load) fcw <= fcw_in;
      if (phase_clr)   acc <= '0;
      else if (enable) acc <= acc + fcw;
    end
  end

  // Stage 1: quadrant and residual capture from the pre-update accumulator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1   <= 1'b0;
      q1   <= '0;
      res1 <= '0;
      amp1 <= '0;
    end else begin
      v1   <= enable;
      q1   <= rot_c[PHASE_W-1:PHASE_W-2];
      res1 <= res_c;
      amp1 <= amp_in;
    end
  end

  // Stage 2: registered CORDIC inputs, updated every cycle and qualified by out_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_in      <= '0;
      y_in      <= '0;
      angle_in  <= '0;
      out_valid <= 1'b0;
    end else begin
      x_in      <= x_c;
      y_in      <= y_c;
      angle_in  <= angle_c;
      out_valid <= v1;
    end
  end

  // Valid sideband matched to the CORDIC pipeline depth.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dly <= '0;
    end else begin
      dly <= {dly[CORDIC_LAT-2:0], out_valid};
    end
  end

  assign cordic_valid = dly[CORDIC_LAT-1];

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Self-checking bench for cordic_phase_gen: constant vector table, hand-written timing
// sequences, and randomized traffic against a per-sample arithmetic reference model.
module tb_cordic_phase_gen;

  localparam int LAT = 17;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        phase_clr;
  logic        fcw_load;
  logic [31:0] fcw_in;
  logic [31:0] phase_off;
  logic [15:0] amp_in;
  logic [15:0] x_in;
  logic [15:0] y_in;
  logic [15:0] angle_in;
  logic        out_valid;
  logic        cordic_valid;

  int n_chk;
  int n_err;

  typedef struct {
    int x;
    int y;
    int a;
    bit v;
  } samp_t;

  typedef struct {
    logic [31:0] off;
    int          amp;
    int          ex;
    int          ey;
    int          ea;
  } vec_t;

  samp_t           hist[$];
  longint unsigned m_acc;
  longint unsigned m_fcw;

  cordic_phase_gen dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .phase_clr    (phase_clr),
    .fcw_in       (fcw_in),
    .fcw_load     (fcw_load),
    .phase_off    (phase_off),
    .amp_in       (amp_in),
    .x_in         (x_in),
    .y_in         (y_in),
    .angle_in     (angle_in),
    .out_valid    (out_valid),
    .cordic_valid (cordic_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One sample from the phase seen at an enabled-or-not edge, straight from the angle arithmetic.
  function automatic samp_t model_sample(input longint unsigned acc, input logic [31:0] off,
                                         input logic [15:0] amp, input logic en);
    samp_t           s;
    longint unsigned rot;
    longint          res;
    longint          p;
    int              q;
    int              a;
    int              na;
    rot = (acc + 64'(off) + 64'd536870912) & 64'hFFFF_FFFF;
    q   = int'(rot >> 30);
    res = longint'(rot & 64'h3FFF_FFFF) - 64'sd536870912;
    p   = res * 64'sd25736;
    s.a = int'(p >>> 30);
    a   = int'($signed(amp));
    na  = (a == -32768) ? 32767 : -a;
    s.x = 0;
    s.y = 0;
    case (q)
      0:       s.x = a;
      1:       s.y = a;
      2:       s.x = na;
      default: s.y = na;
    endcase
    s.v = en;
    return s;
  endfunction

  task automatic model_clear();
    hist.delete();
    m_acc = 0;
    m_fcw = 0;
  endtask

  task automatic check_model();
    samp_t e;
    bit    cv;
    int    n;
    e  = '{0, 0, 0, 1'b0};
    cv = 1'b0;
    n  = hist.size();
    if (n >= 2) e = hist[n-2];
    if (n - 2 - LAT >= 0) cv = hist[n-2-LAT].v;
    chk("model_x", longint'($signed(x_in)), longint'(e.x));
    chk("model_y", longint'($signed(y_in)), longint'(e.y));
    chk("model_angle", longint'($signed(angle_in)), longint'(e.a));
    chk("model_out_valid", longint'(out_valid), longint'(e.v));
    chk("model_cordic_valid", longint'(cordic_valid), longint'(cv));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      hist.push_back(model_sample(m_acc, phase_off, amp_in, enable));
      if (phase_clr)   m_acc = 0;
      else if (enable) m_acc = (m_acc + m_fcw) & 64'hFFFF_FFFF;
      if (fcw_load) m_fcw = 64'(fcw_in);
    end
    #1;
    check_model();
  endtask

  task automatic chk_xya(input string name, input int ex, input int ey, input int ea);
    chk({name, "_x"}, longint'($signed(x_in)), longint'(ex));
    chk({name, "_y"}, longint'($signed(y_in)), longint'(ey));
    chk({name, "_angle"}, longint'($signed(angle_in)), longint'(ea));
  endtask

  task automatic run_pattern(input logic [3:0] pat, output logic [31:0] ov, output logic [31:0] cv);
    ov = '0;
    cv = '0;
    for (int k = 0; k < 32; k++) begin
      enable = (k < 4) ? pat[k] : 1'b0;
      tick();
      ov[k] = out_valid;
      cv[k] = cordic_valid;
    end
  endtask

  vec_t        tbl[10];
  int          cx[5];
  int          cy[5];
  logic [31:0] ov_bits;
  logic [31:0] cv_bits;

  initial begin
    n_chk     = 0;
    n_err     = 0;
    reset     = 1'b0;
    enable    = 1'b0;
    phase_clr = 1'b0;
    fcw_load  = 1'b0;
    fcw_in    = '0;
    phase_off = '0;
    amp_in    = '0;
    model_clear();

    tbl[0] = '{32'h0000_0000,  19898,  19898,      0,      0};
    tbl[1] = '{32'h4000_0000,  19898,      0,  19898,      0};
    tbl[2] = '{32'h8000_0000,  19898, -19898,      0,      0};
    tbl[3] = '{32'hC000_0000,  19898,      0, -19898,      0};
    tbl[4] = '{32'h2000_0000,  19898,      0,  19898, -12868};
    tbl[5] = '{32'h1FFF_FFFF,  19898,  19898,      0,  12867};
    tbl[6] = '{32'h8000_0000, -32768,  32767,      0,      0};
    tbl[7] = '{32'hC000_0000, -32768,      0,  32767,      0};
    tbl[8] = '{32'h4000_0000, -32768,      0, -32768,      0};
    tbl[9] = '{32'hE000_0000,    100,    100,      0, -12868};
    cx = '{19898, 0, -19898, 0, 19898};
    cy = '{0, 19898, 0, -19898, 0};

    // Held in reset, then idle after release.
    repeat (3) tick();
    chk_xya("reset", 0, 0, 0);
    reset = 1'b1;
    repeat (6) tick();
    chk_xya("idle", 0, 0, 0);
    chk("idle_out_valid", longint'(out_valid), 0);

    // Static-phase vector table with fcw=0 and the accumulator cleared.
    fcw_in    = '0;
    fcw_load  = 1'b1;
    phase_clr = 1'b1;
    tick();
    fcw_load  = 1'b0;
    phase_clr = 1'b0;
    enable    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      phase_off = tbl[i].off;
      amp_in    = 16'(tbl[i].amp);
      tick();
      tick();
      chk_xya($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].ea);
      chk($sformatf("vec%0d_out_valid", i), longint'(out_valid), 1);
    end

    // Cardinal phases with fcw = quarter turn, including accumulator wrap.
    phase_off = '0;
    amp_in    = 16'd19898;
    enable    = 1'b0;
    phase_clr = 1'b1;
    fcw_load  = 1'b1;
    fcw_in    = 32'h4000_0000;
    tick();
    phase_clr = 1'b0;
    fcw_load  = 1'b0;
    enable    = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_xya($sformatf("card%0d", k), cx[k], cy[k], 0);
    end

    // Clear beats enable; a newly loaded fcw only affects the following increment.
    phase_clr = 1'b1;
    tick();
    phase_clr = 1'b0;
    fcw_load  = 1'b1;
    fcw_in    = 32'h2000_0000;
    tick();
    fcw_load  = 1'b0;
    tick();
    chk_xya("fcwld0", 19898, 0, 0);
    tick();
    chk_xya("fcwld1", 0, 19898, 0);
    tick();
    chk_xya("fcwld2", -19898, 0, -12868);

    // Drain, then valid-pipeline patterns.
    enable = 1'b0;
    repeat (25) tick();
    run_pattern(4'b0001, ov_bits, cv_bits);
    chk("pulse_out_valid", longint'(ov_bits), longint'(32'h1 << 1));
    chk("pulse_cordic_valid", longint'(cv_bits), longint'(32'h1 << (LAT + 1)));
    run_pattern(4'b1101, ov_bits, cv_bits);
    chk("gap_out_valid", longint'(ov_bits), longint'(32'hD << 1));
    chk("gap_cordic_valid", longint'(cv_bits), longint'(32'hD << (LAT + 1)));

    // Asynchronous reset mid-stream.
    fcw_load = 1'b1;
    fcw_in   = 32'h1234_5678;
    enable   = 1'b1;
    tick();
    fcw_load = 1'b0;
    repeat (20) tick();
    #3;
    reset = 1'b0;
    #1;
    chk_xya("async_rst", 0, 0, 0);
    chk("async_rst_out_valid", longint'(out_valid), 0);
    chk("async_rst_cordic_valid", longint'(cordic_valid), 0);
    model_clear();
    repeat (2) tick();
    reset = 1'b1;
    repeat (25) tick();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      enable    = ($urandom_range(3) != 0);
      phase_clr = ($urandom_range(19) == 0);
      fcw_load  = ($urandom_range(9) == 0);
      fcw_in    = $urandom;
      if ($urandom_range(7) == 0) phase_off = $urandom;
      amp_in    = ($urandom_range(15) == 0) ? 16'h8000 : 16'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
